skinny_sbox_layer_sequencer: RTL and testbench

// - Byte-serial scheduler directly upstream/downstream of the masked 3-share TwoSboxes pipeline
//   in the SKINNY-64 second-order encryption core.
// - Accepts a 3-share 64-bit state and issues one byte (two nibbles) per cycle to the S-box pair.
// - Tracks the fixed pipeline latency with valid tags and reassembles the substituted 3-share state.
// - Stalls issue when fresh randomness is unavailable. Signals completion with a one-cycle done pulse.

---
 rtl/skinny_mask_pkg.sv | 19 +
 rtl/sbox_lat_tracker.sv | 30 +++
 rtl/skinny_sbox_layer_sequencer.sv | 127 ++++++++++++
 tb/tb_skinny_sbox_layer_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/skinny_mask_pkg.sv
// Shared sizing and types for the masked SKINNY-64 second-order core.
// The S-box sequencers and the key-schedule logic import this package.
package skinny_mask_pkg;

    localparam int STATE_W  = 64;
    localparam int NBYTES   = STATE_W / 8;
    localparam int SBOX_LAT = 4;
    localparam int RAND_W   = 144;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef logic [$clog2(NBYTES)-1:0] byte_idx_t;

endpackage

// File: rtl/sbox_lat_tracker.sv
// Valid-tag delay line matching the fixed latency of the TwoSboxes pipeline.
// Shared by the S-box layer sequencer and the key-schedule sequencer.
module sbox_lat_tracker #(
    parameter int SBOX_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tag_in,
    output logic tag_out
);

    logic [SBOX_LAT-1:0] pipe;

    generate
        if (SBOX_LAT == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe <= '0;
                else        pipe <= tag_in;
            end
        end else begin : g_deep
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe <= '0;
                else        pipe <= {pipe[SBOX_LAT-2:0], tag_in};
            end
        end
    endgenerate

    assign tag_out = pipe[SBOX_LAT-1];

endmodule

// File: rtl/skinny_sbox_layer_sequencer.sv
// Byte-serial issue/capture scheduler around the masked 3-share TwoSboxes pair.
// Shares are shifted and reassembled on independent register paths and never combined.
module skinny_sbox_layer_sequencer
    import skinny_mask_pkg::*;
#(
    parameter int STATE_W  = skinny_mask_pkg::STATE_W,
    parameter int SBOX_LAT = skinny_mask_pkg::SBOX_LAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [STATE_W-1:0] s1_in,
    input  logic [STATE_W-1:0] s2_in,
    input  logic [STATE_W-1:0] s3_in,
    input  logic               rnd_valid,
    output logic               rnd_req,
    output logic [7:0]         sb_in1,
    output logic [7:0]         sb_in2,
    output logic [7:0]         sb_in3,
    input  logic [7:0]         sb_out1,
    input  logic [7:0]         sb_out2,
    input  logic [7:0]         sb_out3,
    output logic [STATE_W-1:0] s1_out,
    output logic [STATE_W-1:0] s2_out,
    output logic [STATE_W-1:0] s3_out,
    output logic               busy,
    output logic               done,
    output seq_state_e         dbg_state
);

    localparam int NBYTES = STATE_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    seq_state_e         state, state_nxt;
    logic [CNT_W-1:0]   issue_cnt, cap_cnt;
    logic [STATE_W-1:0] sh1, sh2, sh3;
    logic               issue, tag_out;

    // Randomness handshake: rnd_valid says fresh r sits at the S-box pair this
    // cycle; a byte is issued (and r consumed, rnd_req=1) only in RUN with rnd_valid=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_nxt = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                issue = rnd_valid;
                if (rnd_valid && issue_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (tag_out && cap_cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rnd_req   = issue;
    assign dbg_state = state;

    // Gated to zero outside issue cycles so stale share bytes never toggle the S-box.
    assign sb_in1 = issue ? sh1[7:0] : 8'h00;
    assign sb_in2 = issue ? sh2[7:0] : 8'h00;
    assign sb_in3 = issue ? sh3[7:0] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1       <= '0;
            sh2       <= '0;
            sh3       <= '0;
            issue_cnt <= '0;
        end else if (state == IDLE && load) begin
            sh1       <= s1_in;
            sh2       <= s2_in;
            sh3       <= s3_in;
            issue_cnt <= '0;
        end else if (issue) begin
            sh1       <= sh1 >> 8;
            sh2       <= sh2 >> 8;
            sh3       <= sh3 >> 8;
            issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

    // Only tagged results are written; anything else leaving the S-box is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_out  <= '0;
            s2_out  <= '0;
            s3_out  <= '0;
            cap_cnt <= '0;
        end else if (tag_out) begin
            s1_out[{cap_cnt, 3'b000} +: 8] <= sb_out1;
            s2_out[{cap_cnt, 3'b000} +: 8] <= sb_out2;
            s3_out[{cap_cnt, 3'b000} +: 8] <= sb_out3;
            cap_cnt <= cap_cnt + CNT_W'(1);
        end else if (state == IDLE && load) begin
            cap_cnt <= '0;
        end
    end

    sbox_lat_tracker #(
        .SBOX_LAT(SBOX_LAT)
    ) u_lat_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (issue),
        .tag_out(tag_out)
    );

endmodule

// File: tb/tb_skinny_sbox_layer_sequencer.sv
// Bench for skinny_sbox_layer_sequencer: DUT plus a behavioural masked TwoSboxes
// model with 4-cycle latency and fresh output masks, checked against hand-computed S-box layers.
module tb_skinny_sbox_layer_sequencer;
    import skinny_mask_pkg::*;

    logic        clk, rst_n, load, rnd_valid, rnd_req, busy, done;
    logic [63:0] s1_in, s2_in, s3_in, s1_out, s2_out, s3_out;
    logic [7:0]  sb_in1, sb_in2, sb_in3, sb_out1, sb_out2, sb_out3;
    seq_state_e  dbg_state;

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int loads_acc = 0;

    skinny_sbox_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .s1_in(s1_in), .s2_in(s2_in), .s3_in(s3_in),
        .rnd_valid(rnd_valid), .rnd_req(rnd_req),
        .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
        .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3),
        .s1_out(s1_out), .s2_out(s2_out), .s3_out(s3_out),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- TwoSboxes model (SKINNY-64 S4) ----------------
    function automatic logic [3:0] s4(input logic [3:0] x);
        case (x)
            4'h0: s4 = 4'hC; 4'h1: s4 = 4'h6; 4'h2: s4 = 4'h9; 4'h3: s4 = 4'h0;
            4'h4: s4 = 4'h1; 4'h5: s4 = 4'hA; 4'h6: s4 = 4'h2; 4'h7: s4 = 4'hB;
            4'h8: s4 = 4'h3; 4'h9: s4 = 4'h8; 4'hA: s4 = 4'h5; 4'hB: s4 = 4'hD;
            4'hC: s4 = 4'h4; 4'hD: s4 = 4'hE; 4'hE: s4 = 4'h7; default: s4 = 4'hF;
        endcase
    endfunction

    logic [7:0] px[4], pm1[4], pm2[4];

    always @(posedge clk) begin
        logic [7:0] x;
        x = sb_in1 ^ sb_in2 ^ sb_in3;
        px[0]  <= {s4(x[7:4]), s4(x[3:0])};
        pm1[0] <= 8'($urandom);
        pm2[0] <= 8'($urandom);
        for (int i = 1; i < 4; i++) begin
            px[i]  <= px[i-1];
            pm1[i] <= pm1[i-1];
            pm2[i] <= pm2[i-1];
        end
    end

    assign sb_out1 = pm1[3];
    assign sb_out2 = pm2[3];
    assign sb_out3 = px[3] ^ pm1[3] ^ pm2[3];

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: one expected result per accepted load ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            check_val("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
                check_val("result_xor", s1_out ^ s2_out ^ s3_out, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_run(input string name, input logic [63:0] a1, input logic [63:0] a2,
                          input logic [63:0] a3, input logic [63:0] exp_xor,
                          input logic [31:0] bub, input int exp_done, input bit poke_load);
        logic [63:0] st;
        int req_cnt, done_k, first_k, issued, byte_err, bub_err, busy_err, idle_err;
        st = a1 ^ a2 ^ a3;
        req_cnt = 0; done_k = 0; first_k = 0; issued = 0;
        byte_err = 0; bub_err = 0; busy_err = 0; idle_err = 0;

        @(negedge clk);
        s1_in = a1; s2_in = a2; s3_in = a3;
        load = 1'b1;
        rnd_valid = 1'b1;
        exp_q.push_back(exp_xor);
        loads_acc++;

        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            @(negedge clk);
            load = poke_load && (k == 3);
            rnd_valid = !bub[k];
            #1;
            if (rnd_req) begin
                req_cnt++;
                if (first_k == 0) first_k = k;
                if (issued > 7) byte_err++;
                else if ((sb_in1 ^ sb_in2 ^ sb_in3) != st[issued*8 +: 8]) byte_err++;
                issued++;
            end else if ((sb_in1 | sb_in2 | sb_in3) != 8'h00) begin
                bub_err++;
            end
            if (!busy) busy_err++;
            if (done) done_k = k;
        end

        load = poke_load;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load = 1'b0;
            #1;
            if (busy || done || rnd_req) idle_err++;
        end

        check_val({name, "_done_cycle"}, 64'(done_k), 64'(exp_done));
        check_val({name, "_rnd_req_cnt"}, 64'(req_cnt), 64'd8);
        check_val({name, "_first_issue"}, 64'(first_k), 64'd1);
        check_val({name, "_issue_bytes"}, 64'(byte_err), 64'd0);
        check_val({name, "_bubble_zero"}, 64'(bub_err), 64'd0);
        check_val({name, "_busy_run"}, 64'(busy_err), 64'd0);
        check_val({name, "_idle_after"}, 64'(idle_err), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] r1, r2;
        rst_n = 1'b0; load = 1'b0; rnd_valid = 1'b0;
        s1_in = '0; s2_in = '0; s3_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_ctl", {37'd0, busy, done, rnd_req, sb_in1, sb_in2, sb_in3}, 64'd0);
        check_val("rst_sout", s1_out | s2_out | s3_out, 64'd0);
        check_val("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        do_run("zero", r1, r2, r1 ^ r2, 64'hCCCC_CCCC_CCCC_CCCC, 32'h0, 13, 1'b0);

        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        do_run("seq", r1, r2, r1 ^ r2 ^ 64'hFEDC_BA98_7654_3210,
               64'hF7E4_D583_B2A1_096C, 32'h0, 13, 1'b0);

        // rnd_valid low in RUN cycles 2, 5 and 6
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        do_run("bubble", r1, r2, r1 ^ r2 ^ 64'hFEDC_BA98_7654_3210,
               64'hF7E4_D583_B2A1_096C, 32'h0000_0064, 16, 1'b0);

        // Abort a run two cycles in; its in-flight bytes must not be captured later.
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        @(negedge clk);
        s1_in = r1; s2_in = r2; s3_in = r1 ^ r2 ^ 64'hFEDC_BA98_7654_3210;
        load = 1'b1; rnd_valid = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ctl", {37'd0, busy, done, rnd_req, sb_in1, sb_in2, sb_in3}, 64'd0);
        check_val("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        check_val("mid_rst_sout", s1_out | s2_out | s3_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        do_run("after_rst", r1, r2, r1 ^ r2 ^ 64'h0123_4567_89AB_CDEF,
               64'hC690_1A2B_385D_4E7F, 32'h0, 13, 1'b0);

        // load pulsed during RUN and during DONE must be ignored
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        do_run("poke", r1, r2, r1 ^ r2 ^ 64'h0123_4567_89AB_CDEF,
               64'hC690_1A2B_385D_4E7F, 32'h0, 13, 1'b1);

        repeat (5) @(negedge clk);
        check_val("done_count", 64'(done_cnt), 64'(loads_acc));
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
